keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 40 ++++
 rtl/keypad_fifo.sv | 49 ++++
 rtl/keypad_scanner.sv | 162 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants and types for the matrix keypad scanner.
// Holds the scan FSM encoding, key sentinels and code mapping.
package keypad_pkg;

    localparam logic [0:0] S_SCAN = 1'b0;
    localparam logic [0:0] S_EVAL = 1'b1;

    localparam int IDX_W = 7;
    localparam logic [IDX_W-1:0] NONE = 7'h7F;

    localparam logic [3:0] STAR = 4'hE;
    localparam logic [3:0] HASH = 4'hF;

    // Per-frame tally: key hits (saturating at 2) and first hit index.
    typedef struct packed {
        logic [1:0]       hits;
        logic [IDX_W-1:0] idx;
    } tally_t;

    function automatic logic [3:0] key_to_code(
        input logic [IDX_W-1:0] idx,
        input logic             tel
    );
        logic [3:0] code;
        code = idx[3:0];
        if (tel) begin
            if (idx < 7'd9) begin
                code = idx[3:0] + 4'd1;
            end else if (idx == 7'd9) begin
                code = STAR;
            end else if (idx == 7'd10) begin
                code = 4'd0;
            end else begin
                code = HASH;
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_fifo.sv
// Small key-event buffer with push/full and pop/empty.
// A push while full is accepted only if a pop frees a slot.
module keypad_fifo
    import keypad_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [3:0] din,
    output logic       full,
    input  logic       pop,
    output logic [3:0] dout,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [3:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer bookkeeping; extra MSB separates full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents are masked by empty so need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/keypad_scanner.sv
// Row-strobed keypad scanner with frame debounce and event buffer.
// One frame = ROWS row periods plus a single EVAL cycle.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 3,
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int MAP_MODE       = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [COLS-1:0] col_in,
    output logic [ROWS-1:0] row_drive,
    output logic [3:0]      key_code,
    output logic            key_valid,
    input  logic            key_ready,
    output logic            key_held,
    output logic            overflow,
    input  logic            clear_overflow
);

    localparam int RW = $clog2(ROWS);
    localparam int DW = $clog2(SCAN_DIV);
    localparam logic TEL = (MAP_MODE == 1) && (ROWS == 4) && (COLS == 3);
    localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);

    logic [0:0]       state;
    logic [RW-1:0]    row;
    logic [DW-1:0]    div;
    tally_t           tally;
    tally_t           tally_nxt;
    logic [IDX_W-1:0] prev_cand;
    logic [IDX_W-1:0] committed;
    logic [IDX_W-1:0] cand;
    logic [3:0]       stable;
    logic [3:0]       stable_nxt;
    logic             row_last;
    logic             commit;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             drop;
    logic             ovf;
    logic [3:0]       fifo_dout;

    assign row_last = (state == S_SCAN) && (div == DW'(SCAN_DIV - 1));

    // Fold this row's column sample into the running frame tally.
    always_comb begin
        tally_nxt = tally;
        for (int c = 0; c < COLS; c++) begin
            if (!col_in[c]) begin
                if (tally_nxt.hits == 2'd0) begin
                    tally_nxt.idx = IDX_W'(int'(row) * COLS + c);
                end
                if (tally_nxt.hits != 2'd2) begin
                    tally_nxt.hits = tally_nxt.hits + 2'd1;
                end
            end
        end
    end

    // Frame verdict: a lone key is a candidate, none or ghosting is NONE.
    always_comb begin
        cand = (tally.hits == 2'd1) ? tally.idx : NONE;
        if (cand == prev_cand) begin
            stable_nxt = (stable >= DB) ? DB : stable + 4'd1;
        end else begin
            stable_nxt = 4'd1;
        end
        commit = (state == S_EVAL) && (stable_nxt == DB) &&
                 (cand != committed);
        push   = commit && (cand != NONE);
    end

    // Row sequencing: SCAN walks the rows, EVAL closes the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_SCAN;
            row   <= '0;
            div   <= '0;
            tally <= '0;
        end else begin
            unique case (1'b1)
                (state == S_SCAN): begin
                    if (row_last) begin
                        div   <= '0;
                        tally <= tally_nxt;
                        if (row == RW'(ROWS - 1)) begin
                            state <= S_EVAL;
                            row   <= '0;
                        end else begin
                            row <= row + RW'(1);
                        end
                    end else begin
                        div <= div + DW'(1);
                    end
                end
                (state == S_EVAL): begin
                    state <= S_SCAN;
                    tally <= '0;
                end
            endcase
        end
    end

    // Debounce state and the committed key, updated once per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_cand <= NONE;
            stable    <= '0;
            committed <= NONE;
        end else if (state == S_EVAL) begin
            prev_cand <= cand;
            stable    <= stable_nxt;
            if (commit) committed <= cand;
        end
    end

    assign pop  = !rst && !empty && key_ready;
    assign drop = push && full && !pop;

    // Sticky overflow; a fresh drop wins over a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (clear_overflow) begin
            ovf <= 1'b0;
        end
    end

    keypad_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (key_to_code(cand, TEL)),
        .full  (full),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (empty)
    );

    // Strobe the current row; all rows idle in EVAL and in reset.
    always_comb begin
        row_drive = '1;
        if (!rst && state == S_SCAN) row_drive[row] = 1'b0;
    end

    assign key_valid = !rst && !empty;
    assign key_code  = key_valid ? fifo_dout : 4'd0;
    assign key_held  = !rst && (committed != NONE);
    assign overflow  = !rst && ovf;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a frame-level key model.
// A physical keypad model drives col_in from the pressed-key mask.
module tb_keypad_scanner;

    localparam int ROWS  = 4;
    localparam int COLS  = 3;
    localparam int DEB   = 3;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [COLS-1:0] col_in;
    logic [ROWS-1:0] row_drive;
    logic [3:0]      key_code;
    logic            key_valid;
    logic            key_ready = 1'b0;
    logic            key_held;
    logic            overflow;
    logic            clear_overflow = 1'b0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .ROWS           (ROWS),
        .COLS           (COLS),
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (DEB),
        .FIFO_DEPTH     (DEPTH),
        .MAP_MODE       (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .col_in         (col_in),
        .row_drive      (row_drive),
        .key_code       (key_code),
        .key_valid      (key_valid),
        .key_ready      (key_ready),
        .key_held       (key_held),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [11:0] cur_mask = '0;
    int          exp_q[$];
    int          hist[$];
    int          committed = -1;
    bit          exp_ovf = 1'b0;
    bit          push_to_empty = 1'b0;
    int          push_code = 0;

    // Pressed switches short the driven row onto their column.
    always_comb begin
        col_in = '1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (!row_drive[r] && cur_mask[r*COLS+c]) col_in[c] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int tel(input int i);
        if (i < 9) return i + 1;
        if (i == 9) return 14;
        if (i == 10) return 0;
        return 15;
    endfunction

    function automatic int frame_cand(input logic [11:0] m);
        int n = 0;
        int k = -1;
        for (int i = 0; i < 12; i++) begin
            if (m[i]) begin
                n++;
                k = i;
            end
        end
        return (n == 1) ? k : -1;
    endfunction

    // A key is accepted once it has been the lone key for DEB frames.
    task automatic model_eval(input logic [11:0] m, input bit clr);
        int cand;
        int run;
        bit drop;
        drop = 1'b0;
        push_to_empty = 1'b0;
        cand = frame_cand(m);
        hist.push_back(cand);
        if (hist.size() > DEB) void'(hist.pop_front());
        run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != cand) break;
            run++;
        end
        if (run >= DEB && cand != committed) begin
            committed = cand;
            if (cand >= 0) begin
                if (exp_q.size() < DEPTH) begin
                    push_to_empty = (exp_q.size() == 0);
                    push_code = tel(cand);
                    exp_q.push_back(tel(cand));
                end else begin
                    drop = 1'b1;
                end
            end
        end
        if (drop) exp_ovf = 1'b1;
        else if (clr) exp_ovf = 1'b0;
    endtask

    task automatic wait_eval(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (!rst && row_drive == 4'hF) ok = 1'b1;
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL eval_timeout: no EVAL cycle within 40 clocks");
        end
    endtask

    // Close the current frame, then apply the mask for the next one.
    task automatic frame(input logic [11:0] next_mask, input bit clr,
                         input bit rdy);
        bit ok;
        wait_eval(ok);
        model_eval(cur_mask, clr);
        cur_mask = next_mask;
        clear_overflow = clr;
        @(posedge clk);
        #1;
        clear_overflow = 1'b0;
        if (push_to_empty) begin
            check("latency_valid", key_valid, 1);
            check("latency_code", key_code, push_code);
        end
        key_ready = rdy;
        check("key_held", key_held, int'(committed >= 0));
        check("overflow", overflow, int'(exp_ovf));
    endtask

    task automatic hold(input logic [11:0] m, input int n, input bit rdy);
        for (int i = 0; i < n; i++) frame(m, 1'b0, rdy);
    endtask

    // Monitor: every presented event must match the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && key_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_event: got code %0d expected none",
                             key_code);
                end else if (key_ready) begin
                    check("pop_code", key_code, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    check("stall_code", key_code, exp_q[0]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] m;
        int          len;
        int          a;
        int          b;
        bit          rdy;
        bit          found;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_row_drive", row_drive, 4'hF);
        check("reset_key_valid", key_valid, 0);
        check("reset_key_code", key_code, 0);
        check("reset_key_held", key_held, 0);
        check("reset_overflow", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("first_row_after_reset", row_drive, 4'b1110);
        key_ready = 1'b1;

        // Key '8' (row 2, col 1) held, then released.
        hold(12'b1 << 7, 5, 1'b1);
        hold(12'h000, 5, 1'b1);

        // Key '#' held, then released.
        hold(12'b1 << 11, 5, 1'b1);
        hold(12'h000, 5, 1'b1);

        // Key '5' bouncing every frame, then held.
        for (int i = 0; i < 6; i++) begin
            frame((i % 2 == 0) ? (12'b1 << 4) : 12'h000, 1'b0, 1'b1);
        end
        hold(12'b1 << 4, 5, 1'b1);
        hold(12'h000, 5, 1'b1);

        // Keys '1' and '2' together: ghosted, never accepted.
        hold(12'h003, 5, 1'b1);
        check("ghost_not_held", key_held, 0);
        hold(12'h000, 3, 1'b1);

        // Five presses with the consumer stalled; last one collides
        // with a clear request and must still set overflow.
        for (int k = 0; k < 5; k++) begin
            frame(12'b1 << k, 1'b0, 1'b0);
            frame(12'b1 << k, 1'b0, 1'b0);
            frame(12'b1 << k, 1'b0, 1'b0);
            frame(12'b1 << k, (k == 4), 1'b0);
            hold(12'h000, 4, 1'b0);
        end
        check("overflow_set", overflow, 1);
        check("full_head_code", key_code, 1);
        hold(12'h000, 2, 1'b1);
        check("drained_valid", key_valid, 0);
        frame(12'h000, 1'b1, 1'b1);
        check("overflow_cleared", overflow, 0);

        // Reset in row 1 while an event is buffered.
        key_ready = 1'b0;
        hold(12'b1 << 1, 4, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (row_drive == 4'b1101) found = 1'b1;
        end
        check("found_row1", found, 1);
        rst = 1'b1;
        cur_mask = '0;
        #1;
        check("midscan_rst_row_drive", row_drive, 4'hF);
        check("midscan_rst_valid", key_valid, 0);
        @(posedge clk);
        #1;
        check("rst_held_row_drive", row_drive, 4'hF);
        check("rst_held_valid", key_valid, 0);
        check("rst_held_key_held", key_held, 0);
        exp_q.delete();
        hist.delete();
        committed = -1;
        exp_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("row0_after_midscan_rst", row_drive, 4'b1110);
        key_ready = 1'b1;
        hold(12'h000, 2, 1'b1);
        check("discarded_valid", key_valid, 0);

        // Randomized press/release/ghost segments with random stalls.
        for (int s = 0; s < 30; s++) begin
            case ($urandom_range(0, 3))
                0: m = 12'h000;
                3: begin
                    a = $urandom_range(0, 11);
                    b = (a + 1 + $urandom_range(0, 10)) % 12;
                    m = (12'b1 << a) | (12'b1 << b);
                end
                default: m = 12'b1 << $urandom_range(0, 11);
            endcase
            len = $urandom_range(1, 5);
            rdy = ($urandom_range(0, 3) != 0);
            for (int f = 0; f < len; f++) begin
                frame(m, ($urandom_range(0, 7) == 0), rdy);
            end
        end

        hold(12'h000, 5, 1'b1);
        check("final_valid", key_valid, 0);
        check("missing_events", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
